// File: rtl/pong_comm_pkg.sv
// Shared definitions for the inter-board Pong link (receive endpoint and
// transmit framer): message types, type-byte encodings, payload lengths
// and field widths.
package pong_comm_pkg;

    localparam int BALL_Y_W = 9;
    localparam int VEL_W    = 4;
    localparam int SCORE_W  = 5;

    localparam logic [7:0] TYPE_BALL         = 8'hA1;
    localparam logic [7:0] TYPE_MISS         = 8'hA2;
    localparam logic [7:0] TYPE_NEW_GAME     = 8'hA3;
    localparam logic [7:0] TYPE_NEW_GAME_ACK = 8'hA4;

    localparam logic [1:0] LEN_BALL         = 2'd3;
    localparam logic [1:0] LEN_MISS         = 2'd3;
    localparam logic [1:0] LEN_NEW_GAME     = 2'd1;
    localparam logic [1:0] LEN_NEW_GAME_ACK = 2'd0;

    // Encoding doubles as the bit position of the one-hot type flag.
    typedef enum logic [1:0] {
        MSG_BALL         = 2'd0,
        MSG_MISS         = 2'd1,
        MSG_NEW_GAME     = 2'd2,
        MSG_NEW_GAME_ACK = 2'd3
    } msg_type_t;

    function automatic logic is_type_byte(input logic [7:0] b);
        return (b == TYPE_BALL) || (b == TYPE_MISS) ||
               (b == TYPE_NEW_GAME) || (b == TYPE_NEW_GAME_ACK);
    endfunction

    function automatic msg_type_t byte_to_type(input logic [7:0] b);
        case (b)
            TYPE_BALL:     return MSG_BALL;
            TYPE_MISS:     return MSG_MISS;
            TYPE_NEW_GAME: return MSG_NEW_GAME;
            default:       return MSG_NEW_GAME_ACK;
        endcase
    endfunction

    function automatic logic [1:0] payload_len(input msg_type_t t);
        case (t)
            MSG_BALL:     return LEN_BALL;
            MSG_MISS:     return LEN_MISS;
            MSG_NEW_GAME: return LEN_NEW_GAME;
            default:      return LEN_NEW_GAME_ACK;
        endcase
    endfunction

    // Flag order: {new_game_ack, new_game, miss, ball}
    function automatic logic [3:0] type_onehot(input msg_type_t t);
        return 4'b0001 << t;
    endfunction

endpackage

// File: rtl/pong_msg_receiver_if.sv
// Message-side bundle of the Pong receiver.
//   master : receiver side - drives the pending message, fields and error
//            pulses, samples message_acked.
//   slave  : game-state consumer side.
interface pong_msg_receiver_if;
    import pong_comm_pkg::*;

    logic                message_acked;
    logic                new_message_received;
    logic                ball_message_rx;
    logic                miss_message_rx;
    logic                new_game_message_rx;
    logic                new_game_ack_message_rx;
    logic [BALL_Y_W-1:0] ball_y_rx;
    logic [VEL_W-1:0]    velocity_x_rx;
    logic [VEL_W-1:0]    velocity_y_rx;
    logic [SCORE_W-1:0]  my_score_rx;
    logic [SCORE_W-1:0]  your_score_rx;
    logic                you_should_serve_rx;
    logic                you_serve_first_rx;
    logic                frame_error;
    logic                overrun;

    modport master (
        input  message_acked,
        output new_message_received, ball_message_rx, miss_message_rx,
               new_game_message_rx, new_game_ack_message_rx, ball_y_rx,
               velocity_x_rx, velocity_y_rx, my_score_rx, your_score_rx,
               you_should_serve_rx, you_serve_first_rx, frame_error, overrun
    );

    modport slave (
        output message_acked,
        input  new_message_received, ball_message_rx, miss_message_rx,
               new_game_message_rx, new_game_ack_message_rx, ball_y_rx,
               velocity_x_rx, velocity_y_rx, my_score_rx, your_score_rx,
               you_should_serve_rx, you_serve_first_rx, frame_error, overrun
    );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser plus bit-level FSM.
// Ports:
//   clock, reset  - system clock, async active-high reset
//   i_rxd         - raw serial line (idles high)
//   rx_byte       - last received byte, valid with byte_valid
//   byte_valid    - one-cycle pulse, cycle after a good stop-bit sample
//   stop_error    - one-cycle pulse, cycle after a low stop-bit sample
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_rxd,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;

    bit_state_t       r_state, w_state_nxt;
    logic             r_sync1, r_sync2;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit_idx, w_bit_idx_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_byte_valid, w_byte_valid_nxt;
    logic             r_stop_error, w_stop_error_nxt;

    // Synchroniser resets to the idle (high) line level so reset release
    // never looks like a start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_stop_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_stop_error <= w_stop_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt + 1'b1;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_byte_valid_nxt = 1'b0;
        w_stop_error_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_sync2) w_state_nxt = S_START;
            end
            S_START: begin
                // Mid-bit check rejects glitches shorter than half a bit.
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt     = '0;
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_nxt     = '0;
                    w_shift_nxt   = {r_sync2, r_shift[7:1]};   // LSB first
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == FULL_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                    if (r_sync2) w_byte_valid_nxt = 1'b1;
                    else         w_stop_error_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign rx_byte    = r_shift;
    assign byte_valid = r_byte_valid;
    assign stop_error = r_stop_error;

endmodule

// File: rtl/pong_msg_receiver.sv
// Receive endpoint of the inter-board Pong link. Deserialises UART bytes,
// parses TYPE/payload/CHK frames, verifies the XOR checksum and presents
// the message under a hold-until-acked handshake.
// Ports:
//   clock, reset - system clock, async active-high reset
//   UART_RXD     - serial input (asynchronous, idles high)
//   msg          - message bundle (master side): message_acked in; pending
//                  flag, one-hot type, fields, frame_error/overrun pulses out
//   good_frames, bad_frames - frame counters, only with PONG_RX_STATS_EN
// Optional build macro: PONG_RX_STATS_EN
module pong_msg_receiver
    import pong_comm_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                UART_RXD,
    pong_msg_receiver_if.master msg
`ifdef PONG_RX_STATS_EN
    ,
    output logic [15:0]         good_frames,
    output logic [7:0]          bad_frames
`endif
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} parse_state_t;

    logic [7:0] w_rx_byte;
    logic       w_byte_valid;
    logic       w_stop_error;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .i_rxd      (UART_RXD),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_byte_valid),
        .stop_error (w_stop_error)
    );

    // ---------------- parser FSM ----------------
    parse_state_t    r_pstate, w_pstate_nxt;
    msg_type_t       r_type, w_type_nxt;
    logic [7:0]      r_xor, w_xor_nxt;
    logic [1:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_b1, w_b1_nxt;      // shadow payload byte 1
    logic [7:0]      r_b2, w_b2_nxt;      // shadow payload byte 2
    logic            r_b3, w_b3_nxt;      // only bit 0 of byte 3 is meaningful
    logic [TO_W-1:0] r_idle, w_idle_nxt;
    logic            w_commit, w_chk_bad, w_timeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pstate <= P_HUNT;
            r_type   <= MSG_BALL;
            r_xor    <= '0;
            r_idx    <= '0;
            r_b1     <= '0;
            r_b2     <= '0;
            r_b3     <= 1'b0;
            r_idle   <= '0;
        end else begin
            r_pstate <= w_pstate_nxt;
            r_type   <= w_type_nxt;
            r_xor    <= w_xor_nxt;
            r_idx    <= w_idx_nxt;
            r_b1     <= w_b1_nxt;
            r_b2     <= w_b2_nxt;
            r_b3     <= w_b3_nxt;
            r_idle   <= w_idle_nxt;
        end
    end

    always_comb begin
        w_pstate_nxt = r_pstate;
        w_type_nxt   = r_type;
        w_xor_nxt    = r_xor;
        w_idx_nxt    = r_idx;
        w_b1_nxt     = r_b1;
        w_b2_nxt     = r_b2;
        w_b3_nxt     = r_b3;
        w_commit     = 1'b0;
        w_chk_bad    = 1'b0;
        w_timeout    = 1'b0;
        // Inter-byte idle counter only runs while inside a frame.
        w_idle_nxt   = (r_pstate == P_HUNT || w_byte_valid) ? '0 : r_idle + 1'b1;

        if (w_stop_error) begin
            w_pstate_nxt = P_HUNT;
        end else if (w_byte_valid) begin
            case (r_pstate)
                P_HUNT: begin
                    // Non-type bytes are line noise or a lost frame tail.
                    if (is_type_byte(w_rx_byte)) begin
                        w_type_nxt   = byte_to_type(w_rx_byte);
                        w_xor_nxt    = w_rx_byte;
                        w_idx_nxt    = '0;
                        w_pstate_nxt = (payload_len(byte_to_type(w_rx_byte)) == 2'd0)
                                       ? P_CHECK : P_PAYLOAD;
                    end
                end
                P_PAYLOAD: begin
                    w_xor_nxt = r_xor ^ w_rx_byte;
                    case (r_idx)
                        2'd0:    w_b1_nxt = w_rx_byte;
                        2'd1:    w_b2_nxt = w_rx_byte;
                        default: w_b3_nxt = w_rx_byte[0];
                    endcase
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx == payload_len(r_type) - 2'd1) w_pstate_nxt = P_CHECK;
                end
                P_CHECK: begin
                    if (w_rx_byte == r_xor) w_commit  = 1'b1;
                    else                    w_chk_bad = 1'b1;
                    w_pstate_nxt = P_HUNT;
                end
                default: w_pstate_nxt = P_HUNT;
            endcase
        end else if (r_pstate != P_HUNT && r_idle == TIMEOUT_LAST) begin
            w_timeout    = 1'b1;
            w_pstate_nxt = P_HUNT;
        end
    end

    // ---------------- commit / handshake ----------------
    logic                r_new_msg;
    logic [3:0]          r_flags;
    logic [BALL_Y_W-1:0] r_ball_y;
    logic [VEL_W-1:0]    r_vx, r_vy;
    logic [SCORE_W-1:0]  r_my_score, r_your_score;
    logic                r_should_serve, r_serve_first;
    logic                r_frame_error, r_overrun;
    logic                w_load, w_drop;

    // An ack in the commit cycle frees the slot for the incoming frame.
    assign w_load = w_commit && (!r_new_msg || msg.message_acked);
    assign w_drop = w_commit && r_new_msg && !msg.message_acked;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_new_msg      <= 1'b0;
            r_flags        <= '0;
            r_ball_y       <= '0;
            r_vx           <= '0;
            r_vy           <= '0;
            r_my_score     <= '0;
            r_your_score   <= '0;
            r_should_serve <= 1'b0;
            r_serve_first  <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_frame_error <= w_stop_error | w_chk_bad | w_timeout;
            r_overrun     <= w_drop;
            if (w_load) begin
                r_new_msg <= 1'b1;
                r_flags   <= type_onehot(r_type);
                case (r_type)
                    MSG_BALL: begin
                        r_ball_y <= {r_b3, r_b1};
                        r_vx     <= r_b2[7:4];
                        r_vy     <= r_b2[3:0];
                    end
                    MSG_MISS: begin
                        // Sender's view of the score is mirrored for us.
                        r_my_score     <= r_b2[SCORE_W-1:0];
                        r_your_score   <= r_b1[SCORE_W-1:0];
                        r_should_serve <= r_b3;
                    end
                    MSG_NEW_GAME: r_serve_first <= r_b1[0];
                    default: ;
                endcase
            end else if (r_new_msg && msg.message_acked) begin
                r_new_msg <= 1'b0;
                r_flags   <= '0;
            end
        end
    end

    assign msg.new_message_received    = r_new_msg;
    assign msg.ball_message_rx         = r_flags[MSG_BALL];
    assign msg.miss_message_rx         = r_flags[MSG_MISS];
    assign msg.new_game_message_rx     = r_flags[MSG_NEW_GAME];
    assign msg.new_game_ack_message_rx = r_flags[MSG_NEW_GAME_ACK];
    assign msg.ball_y_rx               = r_ball_y;
    assign msg.velocity_x_rx           = r_vx;
    assign msg.velocity_y_rx           = r_vy;
    assign msg.my_score_rx             = r_my_score;
    assign msg.your_score_rx           = r_your_score;
    assign msg.you_should_serve_rx     = r_should_serve;
    assign msg.you_serve_first_rx      = r_serve_first;
    assign msg.frame_error             = r_frame_error;
    assign msg.overrun                 = r_overrun;

`ifdef PONG_RX_STATS_EN
    logic [15:0] r_good;
    logic [7:0]  r_bad;
    logic [8:0]  w_bad_sum;

    // Error and overrun may pulse together, so up to two per cycle.
    assign w_bad_sum = {1'b0, r_bad} + {8'd0, r_frame_error} + {8'd0, r_overrun};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_good <= '0;
            r_bad  <= '0;
        end else begin
            if (w_load) r_good <= r_good + 16'd1;
            r_bad <= w_bad_sum[8] ? 8'hFF : w_bad_sum[7:0];
        end
    end

    assign good_frames = r_good;
    assign bad_frames  = r_bad;
`endif

endmodule

// File: tb/tb_pong_msg_receiver.sv
module tb_pong_msg_receiver;
    localparam int CPB = 16;
    localparam int TO  = 400;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rxd   = 1'b1;
`ifdef PONG_RX_STATS_EN
    logic [15:0] good_frames;
    logic [7:0]  bad_frames;
`endif

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic bv_found, bv_nm, bv_nm_after;

    pong_msg_receiver_if u_if ();

    pong_msg_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .UART_RXD (rxd),
        .msg      (u_if)
`ifdef PONG_RX_STATS_EN
        ,
        .good_frames (good_frames),
        .bad_frames  (bad_frames)
`endif
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (u_if.frame_error === 1'b1) fe_cnt++;
        if (u_if.overrun === 1'b1)     ov_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clock); rxd = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clock);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clock);
        rxd = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    // Sends the last byte of a frame while watching for its byte_valid
    // cycle (the commit cycle); optionally acks exactly in that cycle.
    task automatic send_chk(input logic [7:0] b, input logic ack_commit);
        bv_found = 1'b0; bv_nm = 1'b0; bv_nm_after = 1'b0;
        fork
            send_byte(b, 1'b1);
            begin
                for (int i = 0; i < 400 && !bv_found; i++) begin
                    @(negedge clock);
                    if (u_dut.u_rx.byte_valid === 1'b1) begin
                        bv_found = 1'b1;
                        bv_nm    = u_if.new_message_received;
                        if (ack_commit) u_if.message_acked = 1'b1;
                    end
                end
                if (bv_found) begin
                    @(negedge clock);
                    bv_nm_after = u_if.new_message_received;
                    u_if.message_acked = 1'b0;
                end
            end
        join
    endtask

    task automatic do_ack();
        @(negedge clock); u_if.message_acked = 1'b1;
        @(negedge clock); u_if.message_acked = 1'b0;
    endtask

    task automatic test_reset();
        u_if.message_acked = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (u_if.new_message_received !== 1'b0) begin failures++; $display("FAIL reset_new got=%b exp=0", u_if.new_message_received); end
        checks++; if ({u_if.ball_message_rx, u_if.miss_message_rx, u_if.new_game_message_rx, u_if.new_game_ack_message_rx} !== 4'b0) begin failures++; $display("FAIL reset_flags got=nonzero exp=0"); end
        checks++; if ({u_if.ball_y_rx, u_if.velocity_x_rx, u_if.velocity_y_rx, u_if.my_score_rx, u_if.your_score_rx, u_if.you_should_serve_rx, u_if.you_serve_first_rx, u_if.frame_error, u_if.overrun} !== '0) begin failures++; $display("FAIL reset_fields got=nonzero exp=0"); end
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_ball();
        int fe0 = fe_cnt;
        send_byte(8'hA1, 1'b1); send_byte(8'h64, 1'b1); send_byte(8'h3B, 1'b1); send_byte(8'h01, 1'b1);
        send_chk(8'hFF, 1'b0);
        checks++; if (bv_found !== 1'b1) begin failures++; $display("FAIL ball_chk_seen got=%b exp=1", bv_found); end
        checks++; if (bv_nm !== 1'b0) begin failures++; $display("FAIL ball_commit_early got=%b exp=0", bv_nm); end
        checks++; if (bv_nm_after !== 1'b1) begin failures++; $display("FAIL ball_commit_latency got=%b exp=1", bv_nm_after); end
        checks++; if ({u_if.ball_message_rx, u_if.miss_message_rx, u_if.new_game_message_rx, u_if.new_game_ack_message_rx} !== 4'b1000) begin failures++; $display("FAIL ball_flags got=%b%b%b%b exp=1000", u_if.ball_message_rx, u_if.miss_message_rx, u_if.new_game_message_rx, u_if.new_game_ack_message_rx); end
        checks++; if (u_if.ball_y_rx !== 9'd356) begin failures++; $display("FAIL ball_y got=%0d exp=356", u_if.ball_y_rx); end
        checks++; if (u_if.velocity_x_rx !== 4'd3) begin failures++; $display("FAIL ball_vx got=%0d exp=3", u_if.velocity_x_rx); end
        checks++; if (u_if.velocity_y_rx !== 4'hB) begin failures++; $display("FAIL ball_vy got=%h exp=b", u_if.velocity_y_rx); end
        checks++; if (fe_cnt != fe0) begin failures++; $display("FAIL ball_no_error got=%0d exp=0", fe_cnt - fe0); end
        repeat (30) @(negedge clock);
        checks++; if (u_if.new_message_received !== 1'b1) begin failures++; $display("FAIL ball_held got=%b exp=1", u_if.new_message_received); end
        do_ack();
        checks++; if (u_if.new_message_received !== 1'b0 || u_if.ball_message_rx !== 1'b0) begin failures++; $display("FAIL ball_ack_clear got=%b%b exp=00", u_if.new_message_received, u_if.ball_message_rx); end
        checks++; if (u_if.ball_y_rx !== 9'd356) begin failures++; $display("FAIL ball_y_hold got=%0d exp=356", u_if.ball_y_rx); end
    endtask

    task automatic test_miss();
        send_byte(8'hA2, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h01, 1'b1);
        send_chk(8'hA7, 1'b0);
        checks++; if (u_if.miss_message_rx !== 1'b1 || u_if.new_message_received !== 1'b1) begin failures++; $display("FAIL miss_flag got=%b%b exp=11", u_if.miss_message_rx, u_if.new_message_received); end
        checks++; if (u_if.my_score_rx !== 5'd3) begin failures++; $display("FAIL miss_my_score got=%0d exp=3", u_if.my_score_rx); end
        checks++; if (u_if.your_score_rx !== 5'd7) begin failures++; $display("FAIL miss_your_score got=%0d exp=7", u_if.your_score_rx); end
        checks++; if (u_if.you_should_serve_rx !== 1'b1) begin failures++; $display("FAIL miss_serve got=%b exp=1", u_if.you_should_serve_rx); end
        do_ack();
    endtask

    task automatic test_bad_frames();
        int fe0 = fe_cnt;
        send_byte(8'hA4, 1'b1); send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clock);
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL bad_chk_error got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (u_if.new_message_received !== 1'b0) begin failures++; $display("FAIL bad_chk_new got=%b exp=0", u_if.new_message_received); end
        fe0 = fe_cnt;
        send_byte(8'hA4, 1'b0);
        repeat (20) @(negedge clock);
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL stop_bit_error got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (u_if.new_message_received !== 1'b0) begin failures++; $display("FAIL stop_bit_new got=%b exp=0", u_if.new_message_received); end
    endtask

    task automatic test_back_to_back();
        int ov0;
        send_byte(8'hA4, 1'b1); send_chk(8'hA4, 1'b0);
        checks++; if (u_if.new_game_ack_message_rx !== 1'b1 || u_if.new_message_received !== 1'b1) begin failures++; $display("FAIL b2b_first got=%b%b exp=11", u_if.new_game_ack_message_rx, u_if.new_message_received); end
        ov0 = ov_cnt;
        send_byte(8'hA4, 1'b1); send_chk(8'hA4, 1'b0);
        repeat (2) @(negedge clock);
        checks++; if (ov_cnt - ov0 != 1) begin failures++; $display("FAIL b2b_overrun got=%0d exp=1", ov_cnt - ov0); end
        checks++; if (u_if.new_message_received !== 1'b1 || u_if.new_game_ack_message_rx !== 1'b1) begin failures++; $display("FAIL b2b_pending_kept got=%b%b exp=11", u_if.new_message_received, u_if.new_game_ack_message_rx); end
        // Miss frame A2 0A 05 00, CHK = AD, acked in its own commit cycle.
        ov0 = ov_cnt;
        send_byte(8'hA2, 1'b1); send_byte(8'h0A, 1'b1); send_byte(8'h05, 1'b1); send_byte(8'h00, 1'b1);
        send_chk(8'hAD, 1'b1);
        checks++; if (bv_nm_after !== 1'b1) begin failures++; $display("FAIL ack_commit_new got=%b exp=1", bv_nm_after); end
        checks++; if (ov_cnt != ov0) begin failures++; $display("FAIL ack_commit_overrun got=%0d exp=0", ov_cnt - ov0); end
        checks++; if ({u_if.miss_message_rx, u_if.new_game_ack_message_rx} !== 2'b10) begin failures++; $display("FAIL ack_commit_flags got=%b%b exp=10", u_if.miss_message_rx, u_if.new_game_ack_message_rx); end
        checks++; if (u_if.my_score_rx !== 5'd5 || u_if.your_score_rx !== 5'd10) begin failures++; $display("FAIL ack_commit_scores got=%0d/%0d exp=5/10", u_if.my_score_rx, u_if.your_score_rx); end
        do_ack();
        checks++; if (u_if.new_message_received !== 1'b0) begin failures++; $display("FAIL b2b_final_clear got=%b exp=0", u_if.new_message_received); end
    endtask

    task automatic test_timeout();
        int fe0 = fe_cnt;
        send_byte(8'hA3, 1'b1);
        repeat (TO + 10) @(negedge clock);
        checks++; if (fe_cnt - fe0 != 1) begin failures++; $display("FAIL timeout_error got=%0d exp=1", fe_cnt - fe0); end
        checks++; if (u_if.new_message_received !== 1'b0) begin failures++; $display("FAIL timeout_new got=%b exp=0", u_if.new_message_received); end
        send_byte(8'hA3, 1'b1); send_byte(8'h01, 1'b1); send_chk(8'hA2, 1'b0);
        checks++; if (u_if.new_game_message_rx !== 1'b1 || u_if.you_serve_first_rx !== 1'b1) begin failures++; $display("FAIL new_game got=%b%b exp=11", u_if.new_game_message_rx, u_if.you_serve_first_rx); end
        do_ack();
    endtask

    task automatic test_reset_midframe();
        int fe0;
        send_byte(8'hA1, 1'b1); send_byte(8'h64, 1'b1); send_byte(8'h3B, 1'b1); send_byte(8'h01, 1'b1);
        send_chk(8'hFF, 1'b0);
        send_byte(8'hA1, 1'b1); send_byte(8'h64, 1'b1);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if ({u_if.new_message_received, u_if.ball_message_rx, u_if.ball_y_rx, u_if.velocity_x_rx, u_if.velocity_y_rx, u_if.my_score_rx, u_if.your_score_rx, u_if.you_serve_first_rx} !== '0) begin failures++; $display("FAIL midframe_reset got=nonzero exp=0"); end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        fe0 = fe_cnt;
        send_byte(8'h3B, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'hFF, 1'b1);
        checks++; if (u_if.new_message_received !== 1'b0 || fe_cnt != fe0) begin failures++; $display("FAIL midframe_tail got=%b/%0d exp=0/0", u_if.new_message_received, fe_cnt - fe0); end
        send_byte(8'hA2, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h01, 1'b1);
        send_chk(8'hA7, 1'b0);
        checks++; if (u_if.miss_message_rx !== 1'b1 || u_if.my_score_rx !== 5'd3 || u_if.your_score_rx !== 5'd7) begin failures++; $display("FAIL midframe_recover got=%b/%0d/%0d exp=1/3/7", u_if.miss_message_rx, u_if.my_score_rx, u_if.your_score_rx); end
        do_ack();
    endtask

    task automatic test_noise();
        int fe0 = fe_cnt;
        send_byte(8'h55, 1'b1);
        repeat (10) @(negedge clock);
        checks++; if (u_if.new_message_received !== 1'b0 || fe_cnt != fe0) begin failures++; $display("FAIL noise_ignored got=%b/%0d exp=0/0", u_if.new_message_received, fe_cnt - fe0); end
        checks++; if (u_if.my_score_rx !== 5'd3 || u_if.you_should_serve_rx !== 1'b1) begin failures++; $display("FAIL noise_fields got=%0d/%b exp=3/1", u_if.my_score_rx, u_if.you_should_serve_rx); end
    endtask

    initial begin
        test_reset();
        test_ball();
        test_miss();
        test_bad_frames();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        test_noise();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
